// File: rtl/mp8085_pkg.sv
// Shared types and constants for the mp8085 memory subsystem.
package mp8085_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_DONE,
    HOLD,
    DMA_ACC,
    DMA_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_cycle.sv
// One RAM access: latches the command on start and holds it for WAIT_STATES+1 cycles.
module mem_cycle
  import mp8085_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              done_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] wait_cnt;

  // busy doubles as the registered RAM enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      wait_cnt  <= '0;
      cmd_rw    <= RW_READ;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      wait_cnt  <= CNT_W'(WAIT_STATES);
      cmd_rw    <= rw;
      cmd_addr  <= addr;
      cmd_wdata <= wdata;
    end else if (busy) begin
      if (wait_cnt == '0) begin
        busy <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  assign done_c = busy && (wait_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between the CPU and a HOLD/HLDA DMA master,
// with a starvation limit that forces one CPU slot after HOLD_MAX DMA accesses.
module mem_arbiter
  import mp8085_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned HOLD_MAX    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_hold,
  output logic              dma_hlda,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned STARVE_W = 8;

  arb_state_t          state, state_next;
  logic                start_c, sel_dma_c, starve_hit_c, done_c;
  logic                cpu_first;
  logic [STARVE_W-1:0] starve_cnt;
  logic                cyc_rw;
  logic [ADDR_W-1:0]   cyc_addr;
  logic [DATA_W-1:0]   cyc_wdata;

  assign cyc_rw    = sel_dma_c ? dma_rw    : cpu_rw;
  assign cyc_addr  = sel_dma_c ? dma_addr  : cpu_addr;
  assign cyc_wdata = sel_dma_c ? dma_wdata : cpu_wdata;

  mem_cycle #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_STATES(WAIT_STATES)
  ) u_cycle (
    .clk      (clk),
    .reset    (reset),
    .start    (start_c),
    .rw       (cyc_rw),
    .addr     (cyc_addr),
    .wdata    (cyc_wdata),
    .busy     (ram_en),
    .cmd_rw   (ram_rw),
    .cmd_addr (ram_addr),
    .cmd_wdata(ram_wdata),
    .done_c   (done_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus access launch; requests only count in IDLE and HOLD
  always_comb begin
    state_next   = state;
    start_c      = 1'b0;
    sel_dma_c    = 1'b0;
    starve_hit_c = (state == DMA_DONE) && cpu_req &&
                   (starve_cnt == STARVE_W'(HOLD_MAX - 1));
    case (state)
      IDLE: begin
        if (dma_hold && !cpu_first) begin
          state_next = HOLD;
        end else if (cpu_req) begin
          state_next = CPU_ACC;
          start_c    = 1'b1;
        end
      end
      CPU_ACC:  if (done_c) state_next = CPU_DONE;
      CPU_DONE: state_next = IDLE;
      HOLD: begin
        if (!dma_hold) begin
          state_next = IDLE;
        end else if (dma_req) begin
          state_next = DMA_ACC;
          start_c    = 1'b1;
          sel_dma_c  = 1'b1;
        end
      end
      DMA_ACC:  if (done_c) state_next = DMA_DONE;
      DMA_DONE: state_next = (starve_hit_c || !dma_hold) ? IDLE : HOLD;
      default:  state_next = IDLE;
    endcase
  end

  // Starvation tracking: count DMA completions while the CPU waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      cpu_first  <= 1'b0;
    end else begin
      if (!cpu_req || state == CPU_DONE || starve_hit_c) begin
        starve_cnt <= '0;
      end else if (state == DMA_DONE) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (start_c && !sel_dma_c) begin
        cpu_first <= 1'b0;
      end else if (starve_hit_c) begin
        cpu_first <= 1'b1;
      end else if (!cpu_req) begin
        cpu_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_hlda  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_ack  <= (state_next == CPU_DONE);
      dma_ack  <= (state_next == DMA_DONE);
      dma_hlda <= (state_next inside {HOLD, DMA_ACC, DMA_DONE});
      if (done_c && ram_rw == RW_READ) begin
        if (state == CPU_ACC) begin
          cpu_rdata <= ram_rdata;
        end else if (state == DMA_ACC) begin
          dma_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level bus model plus directed scenarios.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WS     = 1;
  localparam int HM     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              dma_hold = 1'b0, dma_req = 1'b0, dma_rw = 1'b0;
  logic              dma_hlda;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              ram_en, ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  logic [7:0] bram [0:65535];
  logic [7:0] mm   [0:65535];

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS), .HOLD_MAX(HM)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_hold(dma_hold), .dma_hlda(dma_hlda),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial forever #5 clk = ~clk;

  // RAM: asynchronous read, write on the clock while enabled
  assign ram_rdata = bram[ram_addr];
  initial forever begin
    @(posedge clk);
    if (ram_en && ram_rw) bram[ram_addr] = ram_wdata;
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bus model: who owns the RAM, how far into the current access we are
  bit         m_grant = 0, m_active = 0, m_dma = 0, m_prio = 0;
  int         m_t = 0, m_streak = 0;
  logic       m_rw = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_cpu_rd = '0, m_dma_rd = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_grant = 0; m_active = 0; m_dma = 0; m_prio = 0; m_t = 0; m_streak = 0;
      m_rw = 1'b0; m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t == WS + 1) begin
          if (m_rw) mm[m_addr] = m_wdata;
          else if (m_dma) m_dma_rd = mm[m_addr];
          else m_cpu_rd = mm[m_addr];
        end else if (m_t == WS + 2) begin
          m_active = 0;
          if (!m_dma) m_streak = 0;
          else begin
            if (cpu_req) begin
              m_streak++;
              if (m_streak == HM) begin
                m_streak = 0; m_prio = 1; m_grant = 0;
              end
            end
            if (!dma_hold) m_grant = 0;
          end
        end
      end else if (m_grant) begin
        if (!dma_hold) m_grant = 0;
        else if (dma_req) begin
          m_active = 1; m_dma = 1; m_t = 0;
          m_rw = dma_rw; m_addr = dma_addr; m_wdata = dma_wdata;
        end
      end else if (dma_hold && !m_prio) begin
        m_grant = 1;
      end else if (cpu_req) begin
        m_active = 1; m_dma = 0; m_t = 0; m_prio = 0;
        m_rw = cpu_rw; m_addr = cpu_addr; m_wdata = cpu_wdata;
      end
      if (!cpu_req) begin m_streak = 0; m_prio = 0; end
    end
  end

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (ram_en) en_cnt++;
    chk("ram_en",    32'(ram_en),    32'(m_active && m_t <= WS));
    chk("cpu_ack",   32'(cpu_ack),   32'(m_active && !m_dma && m_t == WS + 1));
    chk("dma_ack",   32'(dma_ack),   32'(m_active && m_dma && m_t == WS + 1));
    chk("dma_hlda",  32'(dma_hlda),  32'(m_grant));
    chk("ram_rw",    32'(ram_rw),    32'(m_rw));
    chk("ram_addr",  32'(ram_addr),  32'(m_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_dma_rd));
  end

  // which: 0 cpu_ack, 1 dma_ack, 2 hlda high, 3 hlda low, 4 ram_en
  task automatic wait_for(input int which, input int lim, input string nm, output int lat);
    bit hit;
    hit = 0;
    lat = -1;
    for (int i = 1; i <= lim && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = cpu_ack;
        1: hit = dma_ack;
        2: hit = dma_hlda;
        3: hit = !dma_hlda;
        default: hit = ram_en;
      endcase
      if (hit) lat = i;
    end
    chk({"wait_", nm}, 32'(hit), 32'd1);
  endtask

  task automatic cpu_do(input logic rw, input logic [15:0] a, input logic [7:0] d, output int lat);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    wait_for(0, 40, "cpu_ack", lat);
    cpu_req = 1'b0;
  endtask

  initial begin
    int lat, dacks;
    bit seen;
    logic hlda_at_ack;
    for (int a = 0; a < 65536; a++) begin
      bram[a] = init_val(16'(a));
      mm[a]   = init_val(16'(a));
    end
    bram[16'h1234] = 8'hA5;
    mm[16'h1234]   = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_hlda", 32'(dma_hlda), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // CPU read with one wait state
    en_cnt = 0;
    cpu_do(1'b0, 16'h1234, 8'h00, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_en_cycles", 32'(en_cnt), 32'd2);
    chk("rd_data", 32'(cpu_rdata), 32'hA5);

    // Write then read back; write leaves rdata alone
    @(negedge clk);
    cpu_do(1'b1, 16'h0040, 8'h3C, lat);
    chk("wr_keeps_rdata", 32'(cpu_rdata), 32'hA5);
    @(negedge clk);
    cpu_do(1'b0, 16'h0040, 8'h00, lat);
    chk("readback", 32'(cpu_rdata), 32'h3C);

    // Back-to-back: req held through ack starts the next access
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1234;
    wait_for(0, 40, "b2b_first", lat);
    wait_for(0, 40, "b2b_second", lat);
    chk("b2b_interval", 32'(lat), 32'(WS + 3));
    cpu_req = 1'b0;

    // Simultaneous cpu_req and dma_hold: DMA wins
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0040; dma_hold = 1'b1;
    wait_for(2, 10, "hold_grant", lat);
    chk("hold_grant_lat", 32'(lat), 32'd1);
    repeat (5) @(negedge clk);
    chk("cpu_blocked", 32'(ram_en | cpu_ack), 32'd0);
    dma_hold = 1'b0;
    wait_for(3, 10, "hold_release", lat);
    chk("hold_release_lat", 32'(lat), 32'd1);
    wait_for(0, 40, "cpu_after_hold", lat);
    chk("cpu_after_hold_data", 32'(cpu_rdata), 32'h3C);
    cpu_req = 1'b0;

    // Starvation limit: 4 DMA reads, then one forced CPU slot
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    dma_hold = 1'b1; dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h2000;
    dacks = 0; seen = 0; hlda_at_ack = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (dma_ack) dacks++;
      if (cpu_ack) begin
        seen = 1; hlda_at_ack = dma_hlda; cpu_req = 1'b0;
      end
    end
    chk("starve_cpu_served", 32'(seen), 32'd1);
    chk("starve_dma_count", 32'(dacks), 32'd4);
    chk("starve_hlda_low", 32'(hlda_at_ack), 32'd0);
    chk("starve_cpu_data", 32'(cpu_rdata), 32'hA5);
    chk("dma_data", 32'(dma_rdata), 32'h7A);
    wait_for(2, 10, "hlda_regrant", lat);

    // dma_hold drops in the middle of a DMA access
    wait_for(4, 20, "dma_acc", lat);
    dma_hold = 1'b0;
    wait_for(1, 10, "dma_ack_after_drop", lat);
    chk("hlda_during_last_ack", 32'(dma_hlda), 32'd1);
    @(negedge clk);
    chk("hlda_after_last_ack", 32'(dma_hlda), 32'd0);
    dma_req = 1'b0;

    // Reset in the middle of a CPU access
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0040;
    wait_for(4, 10, "cpu_acc", lat);
    #2 reset = 1'b0;
    #1 chk("rst_abort_en", 32'(ram_en), 32'd0);
    chk("rst_abort_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_ack", 32'(cpu_ack), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    cpu_do(1'b0, 16'h1234, 8'h00, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_data", 32'(cpu_rdata), 32'hA5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the CPU memory path (MAR/MBR side) and an external DMA master using 8085-style HOLD/HLDA semantics. Sequences every RAM access, inserting programmable wait states, and returns read data over a req/ack handshake to whichever side owns the bus. Sits between the CPU datapath/controller and the `memory` block; the CPU stalls its machine cycle until `cpu_ack`.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `WAIT_STATES`, 1, extra cycles `ram_en` is held beyond the first (0..15)
- `HOLD_MAX`, 8, DMA accesses allowed while `cpu_req` is pending before the CPU is forced one slot (1..255)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU memory cycle request, held until `cpu_ack`
- `cpu_rw`  in  1  0 = read, 1 = write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  registered read data, valid with `cpu_ack`
- `cpu_ack`  out  1  one-cycle completion pulse
- `dma_hold`  in  1  HOLD request
- `dma_hlda`  out  1  HOLD acknowledge; DMA owns the bus while high
- `dma_req`, `dma_rw`, `dma_addr`, `dma_wdata`  in  1/1/ADDR_W/DATA_W  DMA access, same rules as CPU
- `dma_rdata`  out  DATA_W  registered read data
- `dma_ack`  out  1  one-cycle completion pulse
- `ram_en`, `ram_rw`, `ram_addr`, `ram_wdata`  out  1/1/ADDR_W/DATA_W  RAM command, all registered
- `ram_rdata`  in  DATA_W  RAM read data

## Operation
- FSM states: IDLE, CPU_ACC, CPU_DONE, HOLD, DMA_ACC, DMA_DONE.
- IDLE: if `dma_hold` and not `cpu_first` -> HOLD; else if `cpu_req` -> CPU_ACC (latch rw/addr/wdata, clear `cpu_first`); else stay. Simultaneous `cpu_req` + `dma_hold` with `cpu_first`=0: DMA wins.
- CPU_ACC / DMA_ACC: `ram_en`=1 with latched command; wait counter loads `WAIT_STATES`, decrements each cycle; on count 0 capture `ram_rdata` (reads only) and go to *_DONE.
- CPU_DONE: `cpu_ack`=1, `ram_en`=0 -> IDLE. DMA_DONE: `dma_ack`=1 -> HOLD, or -> IDLE if `cpu_first` just set.
- HOLD: `dma_hlda`=1. `dma_req` -> DMA_ACC. `dma_hold` low -> IDLE. Requests are sampled only in IDLE/HOLD; a requester still holding req the cycle after ack starts a new access.
- Starvation counter: increments on each DMA_DONE while `cpu_req`=1; cleared when `cpu_req`=0 or on CPU_DONE; reaching `HOLD_MAX` sets `cpu_first`, counter clears, DMA_DONE exits to IDLE (HLDA drops), CPU is served once, then HOLD is re-granted if `dma_hold` is still high.
- `dma_hold` dropping during DMA_ACC: access completes, `dma_ack` issued, then IDLE.
- `dma_req` while `dma_hlda`=0 and `cpu_req` outside IDLE are ignored.
- Write accesses leave `*_rdata` unchanged.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; counters and `cpu_first` 0. Reset mid-access aborts it immediately: `ram_en` falls asynchronously, no ack issued.
- Access latency: req sampled at edge N -> `ram_en` high cycles N+1..N+1+WAIT_STATES -> ack high cycle N+2+WAIT_STATES. Back-to-back throughput one access per WAIT_STATES+3 cycles.
- HOLD grant: `dma_hold` sampled in IDLE at edge N -> `dma_hlda` high from cycle N+1. Release: `dma_hold` low sampled in HOLD -> `dma_hlda` low next cycle.
- `*_rdata` changes only on the capture edge; stable until the next read by that side.

## Structure
- Shared package `mp8085_pkg`: state enum `arb_state_t`, constants `RW_READ`=0 / `RW_WRITE`=1, default `ADDR_W`/`DATA_W`.
- One sub-module `mem_cycle`: latched command register plus wait-state counter, start/done interface, instantiated once and steered by the FSM.

## Test plan
- Reset, WAIT_STATES=1: CPU read 0x1234 with RAM returning 0xA5 -> `ram_en` high 2 cycles, `cpu_ack` 3 cycles after req edge, `cpu_rdata`=0xA5.
- CPU write 0x0040<=0x3C then read back -> `ram_rw`=1 then 0, readback 0x3C, `cpu_rdata` unchanged after the write.
- `cpu_req` and `dma_hold` rise same cycle -> `dma_hlda`=1 next cycle, no CPU access until `dma_hold` drops; then CPU access completes.
- HOLD_MAX=4, `cpu_req` held, DMA streams reads -> exactly 4 `dma_ack`, HLDA drops, one `cpu_ack`, HLDA reasserts.
- `dma_hold` drops mid DMA_ACC -> that `dma_ack` still issued, `dma_hlda` low next cycle.
- Assert `reset` low during CPU_ACC -> `ram_en`=0 same cycle, no `cpu_ack`; after release, new request works normally.
